// File: rtl/weight_stream_fetch.sv
// weight_stream_fetch
//   Reads packed BATCH_SIZE-byte words from the synchronous weight ROM and streams
//   them out one byte per valid/ready beat. Each byte is tagged with its segment:
//   even segments are layer weights, odd segments are biases, and layer = seg >> 1.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   start               pulse; starts a run from IDLE or DONE, ignored while busy
//   busy, done          run in progress / run complete (done held until next start)
//   rom_addr, rom_rd    registered ROM word address and read enable
//   rom_data            ROM word, valid one cycle after rom_rd
//   out_data            current byte
//   out_valid/ready     stream handshake; a beat is out_valid && out_ready
//   out_seg             segment 0..11 of the current byte
//   out_seg_last        current byte is the last byte of its segment
//   out_last            current byte is byte TOTAL_BYTES-1
module weight_stream_fetch #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int BATCH_SIZE  = 8,
    parameter int TOTAL_BYTES = 3048
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    output logic                         rom_rd,
    input  logic [DATA_WIDTH*BATCH_SIZE-1:0] rom_data,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   out_seg,
    output logic                         out_seg_last,
    output logic                         out_last
);

    localparam int WORD_W = DATA_WIDTH * BATCH_SIZE;
    localparam int IDX_W  = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam int WORDS  = (TOTAL_BYTES + BATCH_SIZE - 1) / BATCH_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Fixed byte length of each segment.
    function automatic logic [9:0] seg_len(input logic [3:0] s);
        case (s)
            4'd0:                 seg_len = 10'd324;
            4'd1:                 seg_len = 10'd12;
            4'd2, 4'd10:          seg_len = 10'd243;
            4'd4, 4'd6, 4'd8:     seg_len = 10'd729;
            4'd3, 4'd5, 4'd7,
            4'd9:                 seg_len = 10'd9;
            4'd11:                seg_len = 10'd3;
            default:              seg_len = 10'd1;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      hold_q, hold_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]      pf_q, pf_d;
    logic                   pf_vld_q, pf_vld_d;
    logic                   data_vld_q, data_vld_d;   // rom_data valid this cycle
    logic [ADDR_WIDTH-1:0]  wcnt_q, wcnt_d;           // words issued so far
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic                   rom_rd_q, rom_rd_d;
    logic [11:0]            byte_cnt_q, byte_cnt_d;
    logic [9:0]             seg_cnt_q, seg_cnt_d;     // bytes left in segment after current
    logic [3:0]             seg_q, seg_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_seg_last_q, out_seg_last_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   beat;

    assign beat = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        pf_d        = pf_q;
        pf_vld_d    = pf_vld_q;
        data_vld_d  = rom_rd_q;
        wcnt_d      = wcnt_q;
        rom_addr_d  = rom_addr_q;
        rom_rd_d    = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        seg_cnt_d   = seg_cnt_q;
        seg_d       = seg_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_FILL;
                    rom_rd_d    = 1'b1;
                    rom_addr_d  = '0;
                    wcnt_d      = ADDR_WIDTH'(1);
                    byte_cnt_d  = '0;
                    seg_d       = '0;
                    seg_cnt_d   = seg_len(4'd0) - 10'd1;
                    idx_d       = '0;
                    pf_vld_d    = 1'b0;
                    data_vld_d  = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                if (beat) begin
                    if (out_last_q) begin
                        // Run ends here; anything still prefetched or in flight is dropped.
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        pf_vld_d    = 1'b0;
                        data_vld_d  = 1'b0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 12'd1;
                        if (seg_cnt_q == 10'd0) begin
                            seg_d     = seg_q + 4'd1;
                            seg_cnt_d = seg_len(seg_q + 4'd1) - 10'd1;
                        end else begin
                            seg_cnt_d = seg_cnt_q - 10'd1;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            if (pf_vld_q) begin
                                hold_d   = pf_q;
                                pf_vld_d = 1'b0;
                            end else begin
                                out_valid_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end

                // Arriving word goes to hold when nothing is presented, else to prefetch.
                if (data_vld_q && state_d != S_DONE) begin
                    if (!out_valid_d) begin
                        hold_d      = rom_data;
                        idx_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = S_STREAM;
                    end else begin
                        pf_d     = rom_data;
                        pf_vld_d = 1'b1;
                    end
                end

                // One read in flight at most, and only into an empty prefetch slot.
                if (state_d != S_DONE && !pf_vld_q && !rom_rd_q && !data_vld_q &&
                    wcnt_q < ADDR_WIDTH'(WORDS)) begin
                    rom_rd_d   = 1'b1;
                    rom_addr_d = wcnt_q;
                    wcnt_d     = wcnt_q + ADDR_WIDTH'(1);
                end
            end
        endcase

        busy_d         = (state_d == S_FILL) || (state_d == S_STREAM);
        done_d         = (state_d == S_DONE);
        out_seg_last_d = out_valid_d && (seg_cnt_d == 10'd0);
        out_last_d     = out_valid_d && (byte_cnt_d == 12'(TOTAL_BYTES - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            hold_q         <= '0;
            idx_q          <= '0;
            pf_q           <= '0;
            pf_vld_q       <= 1'b0;
            data_vld_q     <= 1'b0;
            wcnt_q         <= '0;
            rom_addr_q     <= '0;
            rom_rd_q       <= 1'b0;
            byte_cnt_q     <= '0;
            seg_cnt_q      <= '0;
            seg_q          <= '0;
            out_valid_q    <= 1'b0;
            out_seg_last_q <= 1'b0;
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            idx_q          <= idx_d;
            pf_q           <= pf_d;
            pf_vld_q       <= pf_vld_d;
            data_vld_q     <= data_vld_d;
            wcnt_q         <= wcnt_d;
            rom_addr_q     <= rom_addr_d;
            rom_rd_q       <= rom_rd_d;
            byte_cnt_q     <= byte_cnt_d;
            seg_cnt_q      <= seg_cnt_d;
            seg_q          <= seg_d;
            out_valid_q    <= out_valid_d;
            out_seg_last_q <= out_seg_last_d;
            out_last_q     <= out_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign out_data     = hold_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign out_valid    = out_valid_q;
    assign out_seg      = seg_q;
    assign out_seg_last = out_seg_last_q;
    assign out_last     = out_last_q;
    assign rom_addr     = rom_addr_q;
    assign rom_rd       = rom_rd_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
